// File: rtl/hevc_pel_packer.sv
// Packs PACK tagged pixels per flow into one wide word with a one-deep hold per tag and round-robin output.
// Optional per-tag completed-block counters (stat_blocks) are built when PEL_PACKER_STATS_EN is defined.
module hevc_pel_packer #(
  parameter int DATA_W    = 8,
  parameter int PACK      = 4,
  parameter int FLUX      = 2,
  parameter int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [TAG_WIDTH+6:0]             size_din,
  input  logic                             size_write,
  input  logic [TAG_WIDTH+DATA_W-1:0]      in_din,
  input  logic                             in_write,
  output logic [FLUX-1:0]                  in_full,
  output logic [TAG_WIDTH+PACK*DATA_W-1:0] out_din,
  output logic                             out_write,
  output logic                             out_last,
  input  logic [FLUX-1:0]                  out_full,
  output logic                             err
`ifdef PEL_PACKER_STATS_EN
  ,
  output logic [FLUX*16-1:0]               stat_blocks
`endif
);

  localparam int WORD_W = PACK * DATA_W;
  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;

  logic [WORD_W-1:0]    pack_q  [FLUX];
  logic [WORD_W-1:0]    hold_q  [FLUX];
  logic [LANE_W-1:0]    lane_q  [FLUX];
  logic [12:0]          pel_q   [FLUX];
  logic [12:0]          total_q [FLUX];
  logic [FLUX-1:0]      cfg_valid_q;
  logic [FLUX-1:0]      pending_q;
  logic [FLUX-1:0]      last_q;
  logic [TAG_WIDTH-1:0] ptr_q;

  logic [TAG_WIDTH-1:0] in_tag;
  logic [TAG_WIDTH-1:0] cfg_tag;
  logic [TAG_WIDTH-1:0] acc_idx;
  logic [TAG_WIDTH-1:0] grant_idx;
  logic [TAG_WIDTH-1:0] ptr_next;
  logic [DATA_W-1:0]    in_pel;
  logic [6:0]           cfg_size;
  logic [12:0]          cfg_total;
  logic                 tag_ok;
  logic                 accept;
  logic                 bad_write;
  logic                 acc_done;
  logic                 acc_end;
  logic                 grant_any;
  logic [FLUX-1:0]      req;
  logic [FLUX-1:0]      grant;
  logic [WORD_W-1:0]    acc_word;
  int                   rr_idx;

  assign in_tag    = in_din[TAG_WIDTH+DATA_W-1:DATA_W];
  assign in_pel    = in_din[DATA_W-1:0];
  assign cfg_tag   = size_din[TAG_WIDTH+6:7];
  assign cfg_size  = size_din[6:0];
  assign cfg_total = {6'd0, cfg_size} * {6'd0, cfg_size};
  assign tag_ok    = {1'b0, in_tag} < (TAG_WIDTH+1)'(FLUX);
  assign acc_idx   = tag_ok ? in_tag : '0;

  // Round-robin grant starting at ptr_q among tags with a held word and no backpressure.
  always_comb begin
    req       = pending_q & ~out_full;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    rr_idx    = 0;
    for (int i = 0; i < FLUX; i++) begin
      rr_idx = (int'(ptr_q) + i) % FLUX;
      if (!grant_any && req[rr_idx]) begin
        grant_any = 1'b1;
        grant_idx = TAG_WIDTH'(rr_idx);
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
    ptr_next = (int'(grant_idx) + 1 == FLUX) ? '0 : grant_idx + 1'b1;
  end

  // A hold register being drained this cycle can take a new word, so only block when it stays occupied.
  assign in_full   = pending_q & (out_full | ~grant);
  assign accept    = in_write & tag_ok & cfg_valid_q[acc_idx] & ~in_full[acc_idx];
  assign bad_write = in_write & ~accept;

  // Lane 0 starts from zero so the unfilled lanes of a short final word read as zero.
  always_comb begin
    acc_word = (lane_q[acc_idx] == '0) ? '0 : pack_q[acc_idx];
    acc_word[int'(lane_q[acc_idx])*DATA_W +: DATA_W] = in_pel;
    acc_end  = (pel_q[acc_idx] == total_q[acc_idx] - 13'd1);
    acc_done = acc_end || (lane_q[acc_idx] == LANE_W'(PACK - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < FLUX; t++) begin
        pack_q[t]  <= '0;
        hold_q[t]  <= '0;
        lane_q[t]  <= '0;
        pel_q[t]   <= '0;
        total_q[t] <= '0;
      end
      cfg_valid_q <= '0;
      pending_q   <= '0;
      last_q      <= '0;
      ptr_q       <= '0;
      out_din     <= '0;
      out_write   <= 1'b0;
      out_last    <= 1'b0;
      err         <= 1'b0;
    end else begin
      for (int t = 0; t < FLUX; t++) begin
        if (grant[t]) pending_q[t] <= 1'b0;
        // A config write wins over a same-cycle pixel and aborts the block in progress.
        if (size_write && cfg_tag == TAG_WIDTH'(t)) begin
          total_q[t]     <= cfg_total;
          cfg_valid_q[t] <= 1'b1;
          pel_q[t]       <= '0;
          lane_q[t]      <= '0;
        end else if (accept && acc_idx == TAG_WIDTH'(t)) begin
          pack_q[t] <= acc_word;
          if (acc_done) begin
            hold_q[t]    <= acc_word;
            pending_q[t] <= 1'b1;
            last_q[t]    <= acc_end;
            lane_q[t]    <= '0;
          end else begin
            lane_q[t] <= lane_q[t] + 1'b1;
          end
          pel_q[t] <= acc_end ? 13'd0 : pel_q[t] + 13'd1;
        end
      end
      if (bad_write) err <= 1'b1;
      out_write <= grant_any;
      out_last  <= grant_any & last_q[grant_idx];
      if (grant_any) begin
        out_din <= {grant_idx, hold_q[grant_idx]};
        ptr_q   <= ptr_next;
      end
    end
  end

`ifdef PEL_PACKER_STATS_EN
  logic [15:0]          blk_cnt_q [FLUX];
  logic [TAG_WIDTH-1:0] out_tag;

  assign out_tag = out_din[TAG_WIDTH+WORD_W-1:WORD_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < FLUX; t++) blk_cnt_q[t] <= '0;
    end else if (out_write && out_last && blk_cnt_q[out_tag] != 16'hFFFF) begin
      blk_cnt_q[out_tag] <= blk_cnt_q[out_tag] + 16'd1;
    end
  end

  always_comb begin
    stat_blocks = '0;
    for (int t = 0; t < FLUX; t++) stat_blocks[t*16 +: 16] = blk_cnt_q[t];
  end
`endif

endmodule

// File: tb/tb_hevc_pel_packer.sv
// Bench for hevc_pel_packer: table of block streams, directed corner sequences and a randomized run
// checked against a chunking reference model (plus a PACK=3 instance for short final words).
module tb_hevc_pel_packer;
  localparam int PACK = 4;

  typedef struct packed {
    logic [31:0] w;
    logic        l;
  } wl_t;

  typedef struct {
    int          tag;
    int          size;
    int          npix;
    int          base;
    int          nwords;
    int          nlast;
    logic [31:0] first;
    logic [31:0] lastw;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  size_din;
  logic        size_write;
  logic [8:0]  in_din;
  logic        in_write;
  logic [1:0]  in_full;
  logic [32:0] out_din;
  logic        out_write;
  logic        out_last;
  logic [1:0]  out_full;
  logic        err;

  logic [7:0]  s3_din;
  logic        s3_write;
  logic [8:0]  i3_din;
  logic        i3_write;
  logic [1:0]  i3_full;
  logic [24:0] o3_din;
  logic        o3_write;
  logic        o3_last;
  logic [1:0]  o3_full;
  logic        e3;

  always #5 clk = ~clk;

  hevc_pel_packer dut (
    .clk(clk), .rst(rst), .size_din(size_din), .size_write(size_write),
    .in_din(in_din), .in_write(in_write), .in_full(in_full),
    .out_din(out_din), .out_write(out_write), .out_last(out_last),
    .out_full(out_full), .err(err)
  );

  hevc_pel_packer #(.PACK(3)) dut3 (
    .clk(clk), .rst(rst), .size_din(s3_din), .size_write(s3_write),
    .in_din(i3_din), .in_write(i3_write), .in_full(i3_full),
    .out_din(o3_din), .out_write(o3_write), .out_last(o3_last),
    .out_full(o3_full), .err(e3)
  );

  int checks = 0;
  int errors = 0;

  int          m_total [2];
  bit          m_cfg   [2];
  int          m_blk   [2];
  logic [7:0]  m_pix   [2][$];
  wl_t         exp_q   [2][$];
  wl_t         got_q   [2][$];
  int          order_q [$];
  wl_t         g3_q    [$];

  function automatic wl_t mk(input logic [31:0] w, input logic l);
    wl_t r;
    r.w = w;
    r.l = l;
    return r;
  endfunction

  always @(negedge clk) begin
    if (out_write) begin
      got_q[out_din[32]].push_back(mk(out_din[31:0], out_last));
      order_q.push_back(int'(out_din[32]));
    end
    if (o3_write) g3_q.push_back(mk({8'h00, o3_din[23:0]}, o3_last));
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Spec-level model: each block of SIZE*SIZE pixels is cut into PACK-pixel words, last one zero-padded.
  function automatic void model_push(input int tag, input logic [7:0] p);
    logic [31:0] w;
    bit          fin;
    m_pix[tag].push_back(p);
    m_blk[tag]++;
    fin = (m_blk[tag] == m_total[tag]);
    if (m_pix[tag].size() == PACK || fin) begin
      w = '0;
      for (int j = 0; j < m_pix[tag].size(); j++) w[j*8 +: 8] = m_pix[tag][j];
      exp_q[tag].push_back(mk(w, fin));
      m_pix[tag].delete();
      if (fin) m_blk[tag] = 0;
    end
  endfunction

  function automatic void model_reset();
    for (int t = 0; t < 2; t++) begin
      m_total[t] = 0;
      m_cfg[t]   = 1'b0;
      m_blk[t]   = 0;
      m_pix[t].delete();
      exp_q[t].delete();
      got_q[t].delete();
    end
    order_q.delete();
    g3_q.delete();
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    size_write = 1'b0;
    in_write = 1'b0;
    out_full = 2'b00;
    s3_write = 1'b0;
    i3_write = 1'b0;
    o3_full = 2'b00;
    tick(2);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cfg(input int tag, input int size);
    size_din = {1'(tag), 7'(size)};
    size_write = 1'b1;
    tick(1);
    size_write = 1'b0;
    m_total[tag] = size * size;
    m_cfg[tag]   = 1'b1;
    m_blk[tag]   = 0;
    m_pix[tag].delete();
  endtask

  // Honours in_full; a stuck backpressure is released after a few cycles so the wait stays bounded.
  task automatic send(input int tag, input logic [7:0] p);
    int g = 0;
    while (in_full[tag] && g < 50) begin
      if (g > 3) out_full[tag] = 1'b0;
      tick(1);
      g++;
    end
    if (in_full[tag]) begin
      checks++;
      errors++;
      $display("FAIL in_full_timeout tag=%0d actual=1 required=0", tag);
      return;
    end
    in_din = {1'(tag), p};
    in_write = 1'b1;
    tick(1);
    in_write = 1'b0;
    if (m_cfg[tag]) model_push(tag, p);
  endtask

  task automatic raw(input int tag, input logic [7:0] p, input bit acc);
    in_din = {1'(tag), p};
    in_write = 1'b1;
    tick(1);
    in_write = 1'b0;
    if (acc) model_push(tag, p);
  endtask

  task automatic compare(input string name);
    for (int t = 0; t < 2; t++) begin
      check($sformatf("%s t%0d words", name, t), 64'(got_q[t].size()), 64'(exp_q[t].size()));
      for (int i = 0; i < got_q[t].size() && i < exp_q[t].size(); i++) begin
        check($sformatf("%s t%0d w%0d data", name, t, i), 64'(got_q[t][i].w), 64'(exp_q[t][i].w));
        check($sformatf("%s t%0d w%0d last", name, t, i), 64'(got_q[t][i].l), 64'(exp_q[t][i].l));
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt [5];
    int          nl;
    int          sz0, sz1, t;
    logic [31:0] w;

    vt[0] = '{1, 16,  256, 'h00,   64, 1, 32'h03020100, 32'hFFFEFDFC};
    vt[1] = '{0,  4,   16, 'hA0,    4, 1, 32'hA3A2A1A0, 32'hAFAEADAC};
    vt[2] = '{1,  8,   64, 'h10,   16, 1, 32'h13121110, 32'h4F4E4D4C};
    vt[3] = '{1,  4,   48, 'h20,   12, 3, 32'h23222120, 32'h4F4E4D4C};
    vt[4] = '{0, 64, 4096, 'h00, 1024, 1, 32'h03020100, 32'hFFFEFDFC};

    in_din = '0; size_din = '0; s3_din = '0; i3_din = '0;
    do_reset();

    check("rst out_write", 64'(out_write), 0);
    check("rst out_last",  64'(out_last), 0);
    check("rst out_din",   64'(out_din), 0);
    check("rst err",       64'(err), 0);
    check("rst in_full",   64'(in_full), 0);

    for (int k = 0; k < 5; k++) begin
      do_reset();
      cfg(vt[k].tag, vt[k].size);
      for (int i = 0; i < vt[k].npix; i++) send(vt[k].tag, 8'(vt[k].base + i));
      tick(8);
      t = vt[k].tag;
      check($sformatf("vec%0d count", k), 64'(got_q[t].size()), 64'(vt[k].nwords));
      if (got_q[t].size() > 0) begin
        check($sformatf("vec%0d first", k), 64'(got_q[t][0].w), 64'(vt[k].first));
        check($sformatf("vec%0d lastw", k), 64'(got_q[t][got_q[t].size()-1].w), 64'(vt[k].lastw));
        check($sformatf("vec%0d lastflag", k), 64'(got_q[t][got_q[t].size()-1].l), 1);
      end
      nl = 0;
      foreach (got_q[t][i]) if (got_q[t][i].l) nl++;
      check($sformatf("vec%0d nlast", k), 64'(nl), 64'(vt[k].nlast));
      check($sformatf("vec%0d err", k), 64'(err), 0);
      compare($sformatf("vec%0d", k));
    end

    // Interleaved flows on both tags.
    do_reset();
    cfg(0, 4);
    cfg(1, 8);
    for (int i = 0; i < 64; i++) begin
      if (i < 16) send(0, 8'(8'hA0 + i));
      send(1, 8'(8'h10 + i));
    end
    tick(8);
    check("ilv count0", 64'(got_q[0].size()), 4);
    check("ilv count1", 64'(got_q[1].size()), 16);
    check("ilv err", 64'(err), 0);
    compare("ilv");

    // Both tags pending in the same cycle: grants alternate.
    do_reset();
    cfg(0, 4);
    cfg(1, 4);
    out_full = 2'b11;
    for (int i = 0; i < 4; i++) send(0, 8'(i));
    for (int i = 0; i < 4; i++) send(1, 8'(8'h40 + i));
    check("alt in_full", 64'(in_full), 2'b11);
    check("alt held", 64'(order_q.size()), 0);
    out_full = 2'b00;
    tick(4);
    out_full = 2'b11;
    for (int i = 4; i < 8; i++) send(0, 8'(i));
    for (int i = 4; i < 8; i++) send(1, 8'(8'h40 + i));
    out_full = 2'b00;
    tick(4);
    check("alt order size", 64'(order_q.size()), 4);
    if (order_q.size() == 4) begin
      check("alt order0", 64'(order_q[0]), 0);
      check("alt order1", 64'(order_q[1]), 1);
      check("alt order2", 64'(order_q[2]), 0);
      check("alt order3", 64'(order_q[3]), 1);
    end
    compare("alt");

    // Backpressure on tag1 after its first word, plus a write while full.
    do_reset();
    cfg(1, 16);
    for (int i = 0; i < 4; i++) send(1, 8'(i));
    tick(3);
    check("bp first out", 64'(got_q[1].size()), 1);
    out_full[1] = 1'b1;
    for (int i = 4; i < 8; i++) begin
      check($sformatf("bp in_full pre%0d", i), 64'(in_full[1]), 0);
      raw(1, 8'(i), 1'b1);
    end
    check("bp in_full rise", 64'(in_full[1]), 1);
    check("bp err before", 64'(err), 0);
    raw(1, 8'hEE, 1'b0);
    check("bp err full write", 64'(err), 1);
    tick(5);
    check("bp stalled", 64'(got_q[1].size()), 1);
    out_full[1] = 1'b0;
    for (int i = 8; i < 256; i++) send(1, 8'(i));
    tick(8);
    check("bp err sticky", 64'(err), 1);
    compare("bp");

    // Write to an unconfigured tag, then reset clears everything.
    do_reset();
    raw(1, 8'h55, 1'b0);
    tick(1);
    check("uncfg err", 64'(err), 1);
    tick(4);
    check("uncfg no out", 64'(got_q[1].size() + got_q[0].size()), 0);
    do_reset();
    check("rst2 err", 64'(err), 0);
    check("rst2 out_write", 64'(out_write), 0);
    check("rst2 out_din", 64'(out_din), 0);
    check("rst2 out_last", 64'(out_last), 0);
    check("rst2 in_full", 64'(in_full), 0);

    // Reset mid-block discards the partial block.
    cfg(0, 16);
    for (int i = 0; i < 10; i++) send(0, 8'(i));
    do_reset();
    cfg(0, 4);
    for (int i = 0; i < 16; i++) send(0, 8'(8'h80 + i));
    tick(8);
    check("midrst count", 64'(got_q[0].size()), 4);
    if (got_q[0].size() > 0) check("midrst first", 64'(got_q[0][0].w), 32'h83828180);
    compare("midrst");

    // PACK=3 instance: 16 pixels make five full words and one short final word.
    s3_din = {1'b0, 7'd4};
    s3_write = 1'b1;
    tick(1);
    s3_write = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      i3_din = {1'b0, 8'(i)};
      i3_write = 1'b1;
      tick(1);
    end
    i3_write = 1'b0;
    tick(6);
    check("p3 count", 64'(g3_q.size()), 6);
    for (int k = 0; k < 6 && k < g3_q.size(); k++) begin
      w = '0;
      for (int j = 0; j < 3; j++) if (k*3 + j + 1 <= 16) w[j*8 +: 8] = 8'(k*3 + j + 1);
      check($sformatf("p3 w%0d data", k), 64'(g3_q[k].w), 64'(w));
      check($sformatf("p3 w%0d last", k), 64'(g3_q[k].l), 64'(k == 5));
    end
    check("p3 err", 64'(e3), 0);

    // Randomized traffic with random backpressure.
    do_reset();
    sz0 = 4 << $urandom_range(0, 2);
    sz1 = 4 << $urandom_range(0, 1);
    cfg(0, sz0);
    cfg(1, sz1);
    for (int n = 0; n < 1500; n++) begin
      t = int'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) begin
        out_full = 2'($urandom);
        tick(1);
      end
      if ($urandom_range(0, 5) == 0) tick(1);
      send(t, 8'($urandom));
    end
    out_full = 2'b00;
    tick(10);
    check("rnd err", 64'(err), 0);
    compare("rnd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
